// File: rtl/rvfi_pc_stream_gen.sv
// Synthetic RVFI retirement stream: LFSR-driven bundles with consecutive orders and
// chained PCs, plus an optional single-shot pc_rdata corruption for negative tests.
module rvfi_pc_stream_gen #(
  parameter int          NRET = 2,
  parameter int          XLEN = 32,
  parameter logic [31:0] SEED = 32'h1
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   i_enable,
  input  logic [XLEN-1:0]        i_start_pc,
  input  logic                   i_inject_en,
  input  logic [63:0]            i_inject_order,
  input  logic [XLEN-1:0]        i_inject_xor,
  output logic [NRET-1:0]        o_rvfi_valid,
  output logic [64*NRET-1:0]     o_rvfi_order,
  output logic [XLEN*NRET-1:0]   o_rvfi_pc_rdata,
  output logic [XLEN*NRET-1:0]   o_rvfi_pc_wdata,
  output logic [63:0]            o_next_order,
  output logic                   o_fault_fired
);

  localparam logic [31:0] LFSR_TAPS = 32'h80200003;

  logic [XLEN-1:0]      r_pc;
  logic [63:0]          r_order;
  logic [31:0]          r_lfsr;
  logic                 r_fired;
  logic [NRET-1:0]      r_valid;
  logic [64*NRET-1:0]   r_order_out;
  logic [XLEN*NRET-1:0] r_rdata;
  logic [XLEN*NRET-1:0] r_wdata;

  logic [31:0]          w_lfsr_next;
  logic [31:0]          w_count;
  logic [31:0]          w_rot;
  logic [31:0]          w_slot;
  logic [63:0]          w_slot_order;
  logic [XLEN-1:0]      w_step0;
  logic [XLEN-1:0]      w_pc_next;
  logic [NRET-1:0]      w_valid;
  logic [64*NRET-1:0]   w_order;
  logic [XLEN*NRET-1:0] w_rdata;
  logic [XLEN*NRET-1:0] w_wdata;
  logic                 w_hit;

  assign w_lfsr_next = {1'b0, r_lfsr[31:1]} ^ (r_lfsr[0] ? LFSR_TAPS : 32'h0);

  // Only the first slot may branch, so pc_j has the closed form pc_q + step0 + 4*(j-1).
  always_comb begin
    w_valid      = '0;
    w_order      = '0;
    w_rdata      = '0;
    w_wdata      = '0;
    w_hit        = 1'b0;
    w_slot       = '0;
    w_slot_order = '0;
    w_count      = 32'(r_lfsr[7:0]) % 32'(NRET + 1);
    w_rot        = 32'(r_lfsr[27:24]) % 32'(NRET);
    w_step0      = (r_lfsr[10:8] == 3'd0) ?
                   {{(XLEN-10){r_lfsr[23]}}, r_lfsr[23:16], 2'b00} : XLEN'(4);
    w_pc_next    = (w_count == 32'd0) ? r_pc :
                   r_pc + w_step0 + XLEN'((w_count - 32'd1) << 2);
    for (int c = 0; c < NRET; c++) begin
      w_slot = (32'(c) + 32'(NRET) - w_rot) % 32'(NRET);
      if (w_slot < w_count) begin
        w_slot_order                = r_order + 64'(w_slot);
        w_valid[c]                  = 1'b1;
        w_order[c*64 +: 64]         = w_slot_order;
        w_wdata[c*XLEN +: XLEN]     = r_pc + w_step0 + XLEN'(w_slot << 2);
        w_rdata[c*XLEN +: XLEN]     = (w_slot == 32'd0) ? r_pc :
                                      r_pc + w_step0 + XLEN'((w_slot - 32'd1) << 2);
        if (i_inject_en && (w_slot_order == i_inject_order)) begin
          w_rdata[c*XLEN +: XLEN] = w_rdata[c*XLEN +: XLEN] ^ i_inject_xor;
          w_hit                   = 1'b1;
        end
      end
    end
  end

  // The corruption only touches the emitted rdata; the internal chain stays intact.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_pc        <= i_start_pc & ~(XLEN'(3));
      r_order     <= '0;
      r_lfsr      <= SEED;
      r_fired     <= 1'b0;
      r_valid     <= '0;
      r_order_out <= '0;
      r_rdata     <= '0;
      r_wdata     <= '0;
    end else if (i_enable) begin
      r_valid     <= w_valid;
      r_order_out <= w_order;
      r_rdata     <= w_rdata;
      r_wdata     <= w_wdata;
      r_order     <= r_order + 64'(w_count);
      r_pc        <= w_pc_next;
      r_lfsr      <= w_lfsr_next;
      if (w_hit) begin
        r_fired <= 1'b1;
      end
    end else begin
      r_valid     <= '0;
      r_order_out <= '0;
      r_rdata     <= '0;
      r_wdata     <= '0;
    end
  end

  assign o_rvfi_valid    = r_valid;
  assign o_rvfi_order    = r_order_out;
  assign o_rvfi_pc_rdata = r_rdata;
  assign o_rvfi_pc_wdata = r_wdata;
  assign o_next_order    = r_order;
  assign o_fault_fired   = r_fired;

endmodule

// File: tb/tb_rvfi_pc_stream_gen.sv
// Bench for rvfi_pc_stream_gen: three instances (NRET=1,2,4) driven in lockstep, checked
// against a bundle-level model, a stream-property tracker and hand-computed literals.
module tb_rvfi_pc_stream_gen;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic [31:0] startPc = 32'h1003;
  logic        injectEn = 1'b0;
  logic [63:0] injectOrder = 64'd0;
  logic [31:0] injectXor = 32'h0;

  always #5 clock = ~clock;

  logic [0:0]   valid1;
  logic [63:0]  order1;
  logic [31:0]  rd1, wd1;
  logic [63:0]  next1;
  logic         fired1;
  logic [1:0]   valid2;
  logic [127:0] order2;
  logic [63:0]  rd2, wd2;
  logic [63:0]  next2;
  logic         fired2;
  logic [3:0]   valid4;
  logic [255:0] order4;
  logic [127:0] rd4, wd4;
  logic [63:0]  next4;
  logic         fired4;

  rvfi_pc_stream_gen #(.NRET(1), .XLEN(32), .SEED(32'h1)) u_dut1 (
    .clock(clock), .reset(reset), .i_enable(enable), .i_start_pc(startPc),
    .i_inject_en(injectEn), .i_inject_order(injectOrder), .i_inject_xor(injectXor),
    .o_rvfi_valid(valid1), .o_rvfi_order(order1), .o_rvfi_pc_rdata(rd1),
    .o_rvfi_pc_wdata(wd1), .o_next_order(next1), .o_fault_fired(fired1));

  rvfi_pc_stream_gen #(.NRET(2), .XLEN(32), .SEED(32'h101)) u_dut2 (
    .clock(clock), .reset(reset), .i_enable(enable), .i_start_pc(startPc),
    .i_inject_en(injectEn), .i_inject_order(injectOrder), .i_inject_xor(injectXor),
    .o_rvfi_valid(valid2), .o_rvfi_order(order2), .o_rvfi_pc_rdata(rd2),
    .o_rvfi_pc_wdata(wd2), .o_next_order(next2), .o_fault_fired(fired2));

  rvfi_pc_stream_gen #(.NRET(4), .XLEN(32), .SEED(32'h101)) u_dut4 (
    .clock(clock), .reset(reset), .i_enable(enable), .i_start_pc(startPc),
    .i_inject_en(injectEn), .i_inject_order(injectOrder), .i_inject_xor(injectXor),
    .o_rvfi_valid(valid4), .o_rvfi_order(order4), .o_rvfi_pc_rdata(rd4),
    .o_rvfi_pc_wdata(wd4), .o_next_order(next4), .o_fault_fired(fired4));

  logic [3:0]   oValid [3];
  logic [255:0] oOrder [3];
  logic [127:0] oRd [3];
  logic [127:0] oWd [3];
  logic [63:0]  oNext [3];
  logic         oFired [3];

  always_comb begin
    oValid[0] = {3'b0, valid1};   oValid[1] = {2'b0, valid2};   oValid[2] = valid4;
    oOrder[0] = {192'b0, order1}; oOrder[1] = {128'b0, order2}; oOrder[2] = order4;
    oRd[0]    = {96'b0, rd1};     oRd[1]    = {64'b0, rd2};     oRd[2]    = rd4;
    oWd[0]    = {96'b0, wd1};     oWd[1]    = {64'b0, wd2};     oWd[2]    = wd4;
    oNext[0]  = next1;            oNext[1]  = next2;            oNext[2]  = next4;
    oFired[0] = fired1;           oFired[1] = fired2;           oFired[2] = fired4;
  end

  int nChecks = 0;
  int nFails = 0;

  function automatic int nretOf(input int n);
    return (n == 0) ? 1 : ((n == 1) ? 2 : 4);
  endfunction

  function automatic logic [31:0] seedOf(input int n);
    return (n == 0) ? 32'h1 : 32'h101;
  endfunction

  task automatic checkOutput(input string name, input logic [255:0] actual,
                             input logic [255:0] expected);
    nChecks++;
    if (actual !== expected) begin
      nFails++;
      $display("[TB] FAIL %s at %0t: got %0h expected %0h", name, $time, actual, expected);
    end
  endtask

  // Bundle-level model: builds each bundle as a list of slots, then places them on channels.
  logic [31:0]  mPc [3];
  logic [63:0]  mOrder [3];
  logic [31:0]  mLfsr [3];
  logic         mFired [3];
  logic [3:0]   eValid [3];
  logic [255:0] eOrder [3];
  logic [127:0] eRd [3];
  logic [127:0] eWd [3];
  bit           modelReady = 0;

  always @(posedge clock) begin
    for (int n = 0; n < 3; n++) begin
      int k, r, ch, off;
      logic [31:0] pc, nxt, rdv;
      eValid[n] = '0; eOrder[n] = '0; eRd[n] = '0; eWd[n] = '0;
      if (reset) begin
        mPc[n] = startPc & ~32'h3;
        mOrder[n] = 64'd0;
        mLfsr[n] = seedOf(n);
        mFired[n] = 1'b0;
      end else if (enable) begin
        k = int'(mLfsr[n][7:0]) % (nretOf(n) + 1);
        r = int'(mLfsr[n][27:24]) % nretOf(n);
        pc = mPc[n];
        for (int j = 0; j < k; j++) begin
          if (j == 0 && mLfsr[n][10:8] == 3'd0) begin
            off = $signed(mLfsr[n][23:16]);
            nxt = pc + 32'(off * 4);
          end else begin
            nxt = pc + 32'd4;
          end
          ch = (j + r) % nretOf(n);
          rdv = pc;
          if (injectEn && (mOrder[n] + 64'(j) == injectOrder)) begin
            rdv = pc ^ injectXor;
            mFired[n] = 1'b1;
          end
          eValid[n][ch] = 1'b1;
          eOrder[n][ch*64 +: 64] = mOrder[n] + 64'(j);
          eRd[n][ch*32 +: 32] = rdv;
          eWd[n][ch*32 +: 32] = nxt;
          pc = nxt;
        end
        mOrder[n] = mOrder[n] + 64'(k);
        mPc[n] = pc;
        mLfsr[n] = (mLfsr[n] >> 1) ^ (mLfsr[n][0] ? 32'h80200003 : 32'h0);
      end
    end
    if (reset) modelReady = 1;
  end

  always @(negedge clock) begin
    if (modelReady) begin
      for (int n = 0; n < 3; n++) begin
        checkOutput($sformatf("model_n%0d_ctrl", nretOf(n)),
                    {oValid[n], oNext[n], oFired[n]}, {eValid[n], mOrder[n], mFired[n]});
        checkOutput($sformatf("model_n%0d_order", nretOf(n)), oOrder[n], eOrder[n]);
        checkOutput($sformatf("model_n%0d_pc", nretOf(n)), {oRd[n], oWd[n]}, {eRd[n], eWd[n]});
      end
    end
  end

  // Stream tracker: acts as a forward PC checker over the observed outputs.
  bit          trackOn = 0;
  logic [63:0] trNext [3];
  logic [31:0] trLastWd [3];
  logic        trFired [3];
  logic [3:0]  covered [3];
  logic [63:0] trFaultOrder = 64'd5;
  logic [31:0] trFaultXor = 32'h10;

  always @(negedge clock) begin
    if (trackOn) begin
      for (int n = 0; n < 3; n++) begin
        int cnt;
        bit found;
        logic [31:0] mask;
        cnt = 0;
        for (int c = 0; c < 4; c++) if (oValid[n][c]) cnt++;
        for (int s = 0; s < cnt; s++) begin
          found = 0;
          for (int c = 0; c < nretOf(n); c++) begin
            if (oValid[n][c] && oOrder[n][c*64 +: 64] == trNext[n] + 64'(s)) begin
              found = 1;
              mask = (trNext[n] + 64'(s) == trFaultOrder) ? trFaultXor : 32'h0;
              if (trNext[n] + 64'(s) == trFaultOrder) trFired[n] = 1'b1;
              checkOutput("chain_pc_rdata", oRd[n][c*32 +: 32], trLastWd[n] ^ mask);
              trLastWd[n] = oWd[n][c*32 +: 32];
            end
          end
          checkOutput("consecutive_order", found, 1);
        end
        for (int c = 0; c < nretOf(n); c++) begin
          if (!oValid[n][c])
            checkOutput("idle_channel_zero",
                        {oOrder[n][c*64 +: 64], oRd[n][c*32 +: 32], oWd[n][c*32 +: 32]}, 0);
        end
        trNext[n] = trNext[n] + 64'(cnt);
        checkOutput("next_order_count", oNext[n], trNext[n]);
        checkOutput("fault_fired_sticky", oFired[n], trFired[n]);
        covered[n] = covered[n] | oValid[n];
      end
    end
  end

  task automatic applyStimulus(input logic rst, input logic en, input int cycles);
    reset = rst;
    enable = en;
    repeat (cycles) begin
      @(posedge clock);
      #2;
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [63:0] frozen2, frozen4;
    int guard;

    applyStimulus(1'b1, 1'b0, 3);
    checkOutput("reset_valid", valid2, 0);
    checkOutput("reset_next_order", next2, 0);
    checkOutput("reset_fault_fired", fired2, 0);

    for (int n = 0; n < 3; n++) begin
      trNext[n] = 64'd0;
      trLastWd[n] = 32'h1000;
      trFired[n] = 1'b0;
      covered[n] = 4'h0;
    end
    injectEn = 1'b1;
    injectOrder = 64'd5;
    injectXor = 32'h10;
    trackOn = 1;

    applyStimulus(1'b0, 1'b1, 1);
    checkOutput("first_valid", valid2, 2'b01);
    checkOutput("first_order", order2, 128'd0);
    checkOutput("first_pc_rdata", rd2, {32'h0, 32'h1000});
    checkOutput("first_pc_wdata", wd2, {32'h0, 32'h1004});

    applyStimulus(1'b0, 1'b1, 1);
    checkOutput("second_valid", valid2, 2'b11);
    checkOutput("second_order", order2, {64'd2, 64'd1});
    checkOutput("second_pc_rdata", rd2, {32'h1084, 32'h1004});
    checkOutput("second_pc_wdata", wd2, {32'h1088, 32'h1084});
    checkOutput("second_next_order", next2, 3);

    applyStimulus(1'b0, 1'b1, 498);
    trackOn = 0;
    checkOutput("rotation_cover_n4", covered[2], 4'hF);
    checkOutput("rotation_cover_n2", covered[1], 4'h3);
    checkOutput("fault_fired_held", {fired1, fired2, fired4}, 3'b111);

    frozen2 = mOrder[1];
    frozen4 = mOrder[2];
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b0, 1'b0, 1);
      checkOutput("gated_valid", {valid2, valid4}, 0);
      checkOutput("gated_next_order", {next2, next4}, {frozen2, frozen4});
    end

    injectEn = 1'b0;
    startPc = 32'hFFFF_FFFC;
    applyStimulus(1'b1, 1'b0, 1);
    applyStimulus(1'b0, 1'b1, 1);
    checkOutput("wrap_order0_rdata", rd2[31:0], 32'hFFFF_FFFC);
    checkOutput("wrap_order0_wdata", wd2[31:0], 32'h0);
    applyStimulus(1'b0, 1'b1, 1);
    checkOutput("wrap_order1_order", order2[63:0], 64'd1);
    checkOutput("wrap_order1_rdata", rd2[31:0], 32'h0);

    injectEn = 1'b1;
    injectOrder = 64'd10;
    injectXor = 32'h4;
    guard = 0;
    while (mOrder[1] < 64'd37 && guard < 300) begin
      applyStimulus(1'b0, 1'b1, 1);
      guard++;
    end
    checkOutput("reach_order_37", (next2 >= 64'd37), 1);
    checkOutput("midstream_fired", fired2, 1);

    startPc = 32'h2000;
    applyStimulus(1'b1, 1'b1, 1);
    checkOutput("midreset_valid", valid2, 0);
    checkOutput("midreset_next_order", next2, 0);
    checkOutput("midreset_fired_cleared", fired2, 0);
    applyStimulus(1'b0, 1'b1, 1);
    checkOutput("restart_valid", valid2[0], 1);
    checkOutput("restart_order", order2[63:0], 64'd0);
    checkOutput("restart_pc_rdata", rd2[31:0], 32'h2000);

    @(negedge clock);
    $display("TB_RESULT checks=%0d failures=%0d", nChecks, nFails);
    $finish;
  end

endmodule
